// File: rtl/csa_multibyte_sequencer.sv
// rtl/csa_multibyte_sequencer.sv - byte-serial BYTES*8-bit adder time-sharing one 8-bit conditional-sum adder
// Optional subtract mode is enabled by defining CSA_SEQ_SUB_EN.

module conditional_sum_adder (
    input  logic [7:0] x,
    input  logic [7:0] y,
    input  logic       ci,
    output logic [7:0] s,
    output logic       co
);
    logic [4:0] lo;
    logic [4:0] hi0;
    logic [4:0] hi1;

    // Upper nibble is precomputed for both carry-ins; the lower nibble's carry selects.
    always_comb begin
        lo  = {1'b0, x[3:0]} + {1'b0, y[3:0]} + {4'b0000, ci};
        hi0 = {1'b0, x[7:4]} + {1'b0, y[7:4]};
        hi1 = hi0 + 5'd1;
        s   = {(lo[4] ? hi1[3:0] : hi0[3:0]), lo[3:0]};
        co  = lo[4] ? hi1[4] : hi0[4];
    end
endmodule

module csa_multibyte_sequencer #(
    parameter int BYTES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [8*BYTES-1:0]   a,
    input  logic [8*BYTES-1:0]   b,
    input  logic                 cin,
`ifdef CSA_SEQ_SUB_EN
    input  logic                 sub,
`endif
    output logic                 busy,
    output logic                 done,
    output logic [8*BYTES-1:0]   sum,
    output logic                 cout,
    output logic                 ovf
);
    localparam int W  = 8 * BYTES;
    localparam int IW = $clog2(BYTES);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state;
    state_t         state_next;
    logic [W-1:0]   a_l;
    logic [W-1:0]   b_l;
    logic [W-1:0]   b_eff;
    logic [IW-1:0]  idx;
    logic           c;
    logic           last;
    logic [7:0]     add_a;
    logic [7:0]     add_b;
    logic [7:0]     add_s;
    logic           add_co;
    logic           c_init;
`ifdef CSA_SEQ_SUB_EN
    logic           sub_l;
`endif

    always_comb begin
`ifdef CSA_SEQ_SUB_EN
        b_eff  = sub_l ? ~b_l : b_l;
        c_init = sub ? 1'b1 : cin;
`else
        b_eff  = b_l;
        c_init = cin;
`endif
        add_a = a_l[8*idx +: 8];
        add_b = b_eff[8*idx +: 8];
        last  = (idx == IW'(BYTES - 1));
    end

    conditional_sum_adder u_adder (
        .x  (add_a),
        .y  (add_b),
        .ci (c),
        .s  (add_s),
        .co (add_co)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_l   <= '0;
            b_l   <= '0;
            idx   <= '0;
            c     <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
`ifdef CSA_SEQ_SUB_EN
            sub_l <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_l   <= a;
                        b_l   <= b;
                        idx   <= '0;
                        c     <= c_init;
                        sum   <= '0;
                        cout  <= 1'b0;
                        ovf   <= 1'b0;
`ifdef CSA_SEQ_SUB_EN
                        sub_l <= sub;
`endif
                    end
                end
                RUN: begin
                    sum[8*idx +: 8] <= add_s;
                    if (last) begin
                        cout <= add_co;
                        ovf  <= (a_l[W-1] == b_eff[W-1]) && (add_s[7] != a_l[W-1]);
                    end else begin
                        c   <= add_co;
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_csa_multibyte_sequencer.sv
// tb/tb_csa_multibyte_sequencer.sv - randomized scoreboard bench for csa_multibyte_sequencer
// Exercises subtract mode as well when CSA_SEQ_SUB_EN is defined.

module tb_csa_multibyte_sequencer;
    localparam int BYTES = 4;
    localparam int W     = 8 * BYTES;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int           cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    bit   busy_check = 1'b0;
    exp_t sb[$];

    csa_multibyte_sequencer #(.BYTES(BYTES)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef CSA_SEQ_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic ci, input logic s);
        exp_t         e;
        logic [W:0]   full;
        logic [W-1:0] yy;
        logic         cc;
        yy     = s ? ~y : y;
        cc     = s ? 1'b1 : ci;
        full   = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, cc};
        e.sum  = full[W-1:0];
        e.cout = full[W];
        e.ovf  = (x[W-1] == yy[W-1]) && (full[W-1] != x[W-1]);
        e.cyc  = 0;
        return e;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (busy_check) begin
            busy_check <= 1'b0;
            check("busy_fall", {{(W-1){1'b0}}, busy}, '0);
        end
        if (!rst && done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", {{(W-1){1'b0}}, done}, '0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sum", sum, e.sum);
                check("cout", {{(W-1){1'b0}}, cout}, {{(W-1){1'b0}}, e.cout});
                check("ovf", {{(W-1){1'b0}}, ovf}, {{(W-1){1'b0}}, e.ovf});
                check("done_cycle", W'(cyc), W'(e.cyc));
                busy_check <= 1'b1;
            end
        end
    end

    task automatic wait_idle();
        int guard = 0;
        while (busy && guard < 100) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (busy) check("idle_timeout", {{(W-1){1'b0}}, busy}, '0);
    endtask

    // poke holds a conflicting request through RUN and DONE; it must be ignored.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                          input logic ts, input bit poke);
        exp_t e;
        wait_idle();
        a     = ta;
        b     = tb_;
        cin   = tc;
        sub   = ts;
        start = 1'b1;
        e     = model(ta, tb_, tc, ts);
        @(posedge clk);
        #1;
        e.cyc = cyc + BYTES;
        sb.push_back(e);
        if (poke) begin
            a   = 32'h1111_1111;
            b   = 32'h1111_1111;
            cin = 1'b1;
            repeat (BYTES + 1) @(posedge clk);
            #1;
        end
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
    endtask

    initial begin
        // Reset with arbitrary inputs driving.
        start = 1'b1;
        a     = $urandom;
        b     = $urandom;
        cin   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {{(W-1){1'b0}}, busy}, '0);
        check("rst_done", {{(W-1){1'b0}}, done}, '0);
        check("rst_sum", sum, '0);
        check("rst_cout", {{(W-1){1'b0}}, cout}, '0);
        check("rst_ovf", {{(W-1){1'b0}}, ovf}, '0);
        start = 1'b0;
        rst   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_idle", {{(W-1){1'b0}}, busy}, '0);

        run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
        run_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
        run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
        run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 1'b1);

        // Reset in the second RUN cycle discards the operation.
        wait_idle();
        a     = 32'h1234_5678;
        b     = 32'h0FED_CBA9;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrun_busy", {{(W-1){1'b0}}, busy}, '0);
        check("midrun_sum", sum, '0);
        check("midrun_cout", {{(W-1){1'b0}}, cout}, '0);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        run_op(32'd3, 32'd4, 1'b0, 1'b0, 1'b0);

`ifdef CSA_SEQ_SUB_EN
        run_op(32'd5, 32'd7, 1'b0, 1'b1, 1'b0);
        run_op(32'd7, 32'd5, 1'b1, 1'b1, 1'b0);
        run_op(32'h8000_0000, 32'd1, 1'b0, 1'b1, 1'b0);
`endif

        for (int i = 0; i < 60; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            logic         rs;
            ra = $urandom;
            rb = $urandom;
            if (i % 5 == 0) rb = ~ra;
            if (i % 7 == 0) ra = {1'b0, {(W-1){1'b1}}};
`ifdef CSA_SEQ_SUB_EN
            rs = 1'($urandom_range(0, 1));
`else
            rs = 1'b0;
`endif
            run_op(ra, rb, 1'($urandom_range(0, 1)), rs, (i % 9 == 0));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(posedge clk);
            #1;
        end

        begin
            int guard = 0;
            while ((sb.size() != 0 || busy) && guard < 200) begin
                @(posedge clk);
                guard++;
            end
            repeat (3) @(posedge clk);
            check("drain", W'(sb.size()), '0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
